// File: rtl/clk_div_cfg_ctrl.sv
// Runtime enable/ratio controller for the reference-clock divider.
// A ratio change drains to a low divided clock, gates the divider, loads the new ratio, then re-enables it.
module clk_div_cfg_ctrl #(
   parameter logic [3:0] DEFAULT_RATIO = 4'd2,
   parameter int         GAP_CYCLES    = 2,
   parameter int         TIMEOUT       = 32
) (
   input  logic       i_ref_clk,
   input  logic       i_rst_n,
   input  logic       i_ctrl_en,
   input  logic       i_cfg_valid,
   input  logic [3:0] i_cfg_ratio,
   output logic       o_cfg_ready,
   input  logic       i_div_clk,
   output logic       o_clk_en,
   output logic [3:0] o_div_ratio,
   output logic       o_busy,
   output logic       o_cfg_done,
   output logic       o_timeout,
   output logic [2:0] o_dbg_state
);

   // Handshake: a request transfers on a rising edge where i_cfg_valid && o_cfg_ready.
   // The requester keeps i_cfg_valid and i_cfg_ratio stable until that edge; ready never
   // depends on valid, so a held request is simply taken once the FSM is back in IDLE/RUN.

   localparam int WAIT_W = $clog2(TIMEOUT + 1);
   localparam int GAP_W  = $clog2(GAP_CYCLES + 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
   localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RUN   = 3'd1,
      DRAIN = 3'd2,
      GATE  = 3'd3,
      LOAD  = 3'd4
   } state_t;

   state_t            state_q, state_d;
   logic [3:0]        ratio_q;
   logic [3:0]        pending_q;
   logic              upd_q;
   logic [WAIT_W-1:0] wait_cnt;
   logic [GAP_W-1:0]  gap_cnt;
   logic              done_q;
   logic              timeout_q;
   logic              accept;

   assign o_cfg_ready = (state_q == IDLE) || (state_q == RUN);
   assign o_clk_en    = (state_q == RUN) || (state_q == DRAIN);
   assign o_busy      = (state_q == DRAIN) || (state_q == GATE) || (state_q == LOAD);
   assign o_div_ratio = ratio_q;
   assign o_cfg_done  = done_q;
   assign o_timeout   = timeout_q;
   assign o_dbg_state = state_q;
   assign accept      = i_cfg_valid && o_cfg_ready;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (!accept && i_ctrl_en) state_d = RUN;
         RUN:     if (accept || !i_ctrl_en) state_d = DRAIN;
         DRAIN:   if (!i_div_clk || (wait_cnt == WAIT_LAST)) state_d = GATE;
         GATE:    if (gap_cnt == GAP_LAST) state_d = upd_q ? LOAD : IDLE;
         LOAD:    state_d = i_ctrl_en ? RUN : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_ref_clk) begin
      if (!i_rst_n) begin
         state_q   <= IDLE;
         ratio_q   <= DEFAULT_RATIO;
         pending_q <= DEFAULT_RATIO;
         upd_q     <= 1'b0;
         wait_cnt  <= '0;
         gap_cnt   <= '0;
         done_q    <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         done_q    <= 1'b0;
         timeout_q <= 1'b0;

         if (state_q == IDLE && accept) begin
            ratio_q <= i_cfg_ratio;
            done_q  <= 1'b1;
         end

         // A shutdown racing a request still applies the ratio; LOAD then falls to IDLE.
         if (state_q == RUN) begin
            if (accept) begin
               pending_q <= i_cfg_ratio;
               upd_q     <= 1'b1;
            end else if (!i_ctrl_en) begin
               upd_q <= 1'b0;
            end
         end

         if (state_q == LOAD) begin
            ratio_q <= pending_q;
            done_q  <= 1'b1;
         end

         // Leaving DRAIN with the divided clock still high can only be the timeout path.
         if (state_q == DRAIN && state_d == GATE && i_div_clk) timeout_q <= 1'b1;

         if (state_d != state_q)                         wait_cnt <= '0;
         else if (state_q == DRAIN && wait_cnt != '1)    wait_cnt <= wait_cnt + 1'b1;

         if (state_d != state_q)                         gap_cnt <= '0;
         else if (state_q == GATE && gap_cnt != '1)      gap_cnt <= gap_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_clk_div_cfg_ctrl.sv
// Directed bench for clk_div_cfg_ctrl: reset, idle load, drain/gate/load, timeout, shutdown,
// held request across a reconfiguration and reset abandoning an operation.
module tb_clk_div_cfg_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ctrl_en;
   logic       cfg_valid;
   logic [3:0] cfg_ratio;
   logic       cfg_ready;
   logic       div_clk;
   logic       clk_en;
   logic [3:0] div_ratio;
   logic       busy;
   logic       cfg_done;
   logic       timeout;
   logic [2:0] dbg_state;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   clk_div_cfg_ctrl dut (
      .i_ref_clk   (clk),
      .i_rst_n     (rst_n),
      .i_ctrl_en   (ctrl_en),
      .i_cfg_valid (cfg_valid),
      .i_cfg_ratio (cfg_ratio),
      .o_cfg_ready (cfg_ready),
      .i_div_clk   (div_clk),
      .o_clk_en    (clk_en),
      .o_div_ratio (div_ratio),
      .o_busy      (busy),
      .o_cfg_done  (cfg_done),
      .o_timeout   (timeout),
      .o_dbg_state (dbg_state)
   );

   // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      ctrl_en   = 1'b0;
      cfg_valid = 1'b0;
      cfg_ratio = 4'd0;
      div_clk   = 1'b0;
      repeat (3) step();
      rst_n = 1'b1;

      // 1: reset values hold while idle
      for (int i = 0; i < 5; i++) begin
         chk1("rst_clk_en", clk_en, 1'b0);
         chk4("rst_ratio", div_ratio, 4'd2);
         chk1("rst_ready", cfg_ready, 1'b1);
         chk1("rst_busy", busy, 1'b0);
         chk1("rst_done", cfg_done, 1'b0);
         step();
      end

      // 2: load in IDLE, then enable
      cfg_valid = 1'b1; cfg_ratio = 4'd4;
      step();
      cfg_valid = 1'b0;
      chk4("idle_load_ratio", div_ratio, 4'd4);
      chk1("idle_load_done", cfg_done, 1'b1);
      chk1("idle_load_clk_en", clk_en, 1'b0);
      step();
      chk1("idle_done_clears", cfg_done, 1'b0);
      ctrl_en = 1'b1;
      step();
      chk1("run_clk_en", clk_en, 1'b1);
      chk1("run_ready", cfg_ready, 1'b1);
      chk1("run_busy", busy, 1'b0);

      // 3: ratio change with divided clock high, then low
      div_clk = 1'b1;
      cfg_valid = 1'b1; cfg_ratio = 4'd6;
      step();
      cfg_valid = 1'b0;
      chk1("drain_clk_en", clk_en, 1'b1);
      chk1("drain_busy", busy, 1'b1);
      chk1("drain_ready", cfg_ready, 1'b0);
      step();
      step();
      chk1("drain_hold_clk_en", clk_en, 1'b1);
      chk4("drain_hold_ratio", div_ratio, 4'd4);
      div_clk = 1'b0;
      step();
      chk1("gate1_clk_en", clk_en, 1'b0);
      chk1("gate1_timeout", timeout, 1'b0);
      step();
      chk1("gate2_clk_en", clk_en, 1'b0);
      chk4("gate2_ratio", div_ratio, 4'd4);
      step();
      chk1("load_clk_en", clk_en, 1'b0);
      chk1("load_busy", busy, 1'b1);
      chk4("load_ratio_old", div_ratio, 4'd4);
      step();
      chk4("applied_ratio", div_ratio, 4'd6);
      chk1("applied_done", cfg_done, 1'b1);
      chk1("applied_clk_en", clk_en, 1'b1);
      step();
      chk1("applied_done_clears", cfg_done, 1'b0);

      // 4: divided clock stuck high -> 32 DRAIN cycles then timeout pulse
      div_clk = 1'b1;
      cfg_valid = 1'b1; cfg_ratio = 4'd9;
      step();
      cfg_valid = 1'b0;
      repeat (31) step();
      chk1("to_last_drain_clk_en", clk_en, 1'b1);
      chk1("to_last_drain_timeout", timeout, 1'b0);
      step();
      chk1("to_exit_clk_en", clk_en, 1'b0);
      chk1("to_exit_pulse", timeout, 1'b1);
      step();
      chk1("to_pulse_clears", timeout, 1'b0);
      step();
      step();
      chk4("to_ratio_applied", div_ratio, 4'd9);
      chk1("to_done", cfg_done, 1'b1);
      chk1("to_run", clk_en, 1'b1);

      // 5: shutdown from RUN
      div_clk = 1'b0;
      ctrl_en = 1'b0;
      step();
      chk1("sd_drain_clk_en", clk_en, 1'b1);
      chk1("sd_drain_busy", busy, 1'b1);
      step();
      chk1("sd_gate1_clk_en", clk_en, 1'b0);
      chk1("sd_gate1_done", cfg_done, 1'b0);
      step();
      chk1("sd_gate2_done", cfg_done, 1'b0);
      step();
      chk1("sd_idle_busy", busy, 1'b0);
      chk1("sd_idle_ready", cfg_ready, 1'b1);
      chk1("sd_idle_clk_en", clk_en, 1'b0);
      chk1("sd_idle_done", cfg_done, 1'b0);
      chk4("sd_idle_ratio", div_ratio, 4'd9);
      step();
      chk1("sd_stays_idle", clk_en, 1'b0);

      // 6: request held across a reconfiguration, then reset during GATE
      ctrl_en = 1'b1;
      step();
      chk1("r6_run", clk_en, 1'b1);
      cfg_valid = 1'b1; cfg_ratio = 4'd5;
      step();
      cfg_ratio = 4'd15;
      chk1("r6_drain_ready", cfg_ready, 1'b0);
      step();
      chk1("r6_gate_ready", cfg_ready, 1'b0);
      step();
      chk4("r6_gate_ratio", div_ratio, 4'd9);
      step();
      chk1("r6_load_ready", cfg_ready, 1'b0);
      step();
      chk4("r6_applied", div_ratio, 4'd5);
      chk1("r6_run_ready", cfg_ready, 1'b1);
      step();
      cfg_valid = 1'b0;
      chk1("r6_held_accepted", busy, 1'b1);
      chk1("r6_held_drain_en", clk_en, 1'b1);
      step();
      chk1("r6_gate_again", clk_en, 1'b0);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      chk4("r6_rst_ratio", div_ratio, 4'd2);
      chk1("r6_rst_clk_en", clk_en, 1'b0);
      chk1("r6_rst_busy", busy, 1'b0);
      chk1("r6_rst_ready", cfg_ready, 1'b1);
      chk1("r6_rst_done", cfg_done, 1'b0);

      // ratio 0 passes through unchanged
      ctrl_en = 1'b0;
      cfg_valid = 1'b1; cfg_ratio = 4'd0;
      step();
      cfg_valid = 1'b0;
      chk4("ratio0_pass", div_ratio, 4'd0);
      chk1("ratio0_done", cfg_done, 1'b1);
      step();
      chk1("ratio0_idle", clk_en, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
